rc4_encrypt_core: RTL
=====================

Name: rc4_encrypt_core

Overview:
- Transmit-side counterpart of the key-search decryptors: given a 24-bit secret key and a plaintext message RAM, it produces the RC4 ciphertext into a ciphertext RAM.
- The ciphertext image it writes is the content loaded into the encrypted-message ROM of each search core.
- Runs KSA (S init + key schedule) then PRGA with XOR, using the same single-port s_memory style working RAM as the search cores.

Parameters:
- MSG_LEN, 32, message length in bytes.
- ADDR_W, 5, message RAM address width; MSG_LEN <= 2**ADDR_W.
- KEY_BYTES, 3, key length in bytes; key byte n is key[23-8n -: 8], so byte 0 is key[23:16].

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- key  in  24  secret key; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last ciphertext byte is written.
- s_address  out  8  working S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data.
- pt_address  out  ADDR_W  plaintext RAM read address.
- pt_q  in  8  plaintext read data.
- ct_address  out  ADDR_W  ciphertext RAM address.
- ct_data  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write enable.

Behaviour:
- Reset values: busy=0, done=0, all wren=0, all addresses and data=0, i=j=k=0, state IDLE.
- Reset asserted mid-operation aborts immediately. RAM contents are left partial and are not cleaned up.
- RAM timing: the address and wren are registered by the RAM at the clock edge. s_q and pt_q are valid one full cycle after the address is presented.
- Every read is therefore followed by one WAIT state before the data is used. Writes take one cycle.
- Arithmetic: i, j and sum are 8-bit and wrap mod 256. k counts 0..MSG_LEN-1.
- State sequence:
  - IDLE: on start, latch key, clear i/j/k, go to INIT. start is ignored while busy.
  - INIT: write S[i]=i for i=0..255, one per cycle. At i=255 clear i and go to KSA_RD_I.
  - KSA_RD_I: read S[i], then WAIT, then capture si.
  - KSA_J: j = j + si + keybyte[i mod KEY_BYTES]. Use a mod-3 counter, not a divider.
  - KSA_RD_J: read S[j], then WAIT, then capture sj.
  - KSA_WR_I: S[i]=sj.
  - KSA_WR_J: S[j]=si.
  - If i==255, clear i and j and go to PRGA; otherwise increment i and go to KSA_RD_I.
- PRGA, per k:
  - i=i+1.
  - Read S[i] and capture si; j=j+si.
  - Read S[j] and capture sj.
  - Write S[i]=sj, then S[j]=si.
  - Read S[si+sj] to get f, and read pt[k] in parallel (independent RAMs).
  - WRITE_CT: ct_address=k, ct_data=f XOR pt_q, ct_wren=1 for exactly one cycle.
- Completion: after k==MSG_LEN-1 is written, pulse done for one cycle, drop busy the same cycle, and return to IDLE.
- i==j case: both swap writes hit the same address with the original value. The second write must use the captured si so S is unchanged; a raw re-read must not be used.
- wren is never asserted in IDLE or in WAIT states. At most one S write per cycle.
- A start during the done cycle is ignored; a new start is accepted from the following IDLE cycle.

Test Plan:
- Reset mid-INIT (i≈100), then release: outputs at reset values, IDLE. A fresh start completes normally and the ciphertext matches the model.
- Key 24'h000000, plaintext all 0x00: ct equals the C model keystream for key {00,00,00}. Exactly MSG_LEN ct_wren pulses at addresses 0..31, one done pulse.
- Key 24'h0003FF, plaintext "abcdefghijklmnopqrstuvwxyzabcdef": ct matches the model. Feeding ct back as plaintext with the same key reproduces the ASCII string.
- Key that drives j==i in KSA (choose from the model, e.g. first i==j hit): the final S image dumped from the RAM matches the model permutation, and S remains a permutation (each 0..255 appears exactly once).
- start held high continuously through one run: exactly one run per IDLE entry. busy deasserts with done, and the next run starts the cycle after.
- Protocol checker on all runs: no wren in WAIT/IDLE, ct_wren count==MSG_LEN, key changes during busy do not affect output.

Source files
------------

// File: rtl/rc4_encrypt_core_if.sv
// rc4_encrypt_core_if: start/key handshake plus the S, plaintext and ciphertext RAM ports of the RC4 encrypt core.
interface rc4_encrypt_core_if #(
    parameter int ADDR_W    = 5,
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] key;
    logic                   busy;
    logic                   done;
    logic [7:0]             s_address;
    logic [7:0]             s_data;
    logic                   s_wren;
    logic [7:0]             s_q;
    logic [ADDR_W-1:0]      pt_address;
    logic [7:0]             pt_q;
    logic [ADDR_W-1:0]      ct_address;
    logic [7:0]             ct_data;
    logic                   ct_wren;
    modport slave (
        input  start, key, s_q, pt_q,
        output busy, done, s_address, s_data, s_wren, pt_address, ct_address, ct_data, ct_wren
    );
    modport master (
        output start, key, s_q, pt_q,
        input  busy, done, s_address, s_data, s_wren, pt_address, ct_address, ct_data, ct_wren
    );
endinterface

// File: rtl/rc4_encrypt_core.sv
// rc4_encrypt_core: RC4 KSA + PRGA over a single-port S RAM, XORing the keystream into a ciphertext RAM.
module rc4_encrypt_core #(
    parameter int MSG_LEN   = 32,
    parameter int ADDR_W    = 5,
    parameter int KEY_BYTES = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    rc4_encrypt_core_if.slave bus
);
    typedef enum logic [4:0] {
        IDLE, INIT, KSA_RD_I, KSA_WT_I, KSA_J, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J,
        PR_INC, PR_RD_I, PR_WT_I, PR_RD_J, PR_WT_J, PR_WR_I, PR_WR_J, PR_RD_F, PR_WT_F,
        WRITE_CT, DONE
    } state_t;
    localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
    state_t                 state_q, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, x_q, x_d;
    logic [ADDR_W-1:0]      k_q, k_d;
    logic [KW-1:0]          km_q, km_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             key_byte;
    // km_q is the running i mod KEY_BYTES; byte 0 sits in the top byte of the key
    assign key_byte = 8'(key_q >> (8 * (KEY_BYTES - 1 - int'(km_q))));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            x_q     <= '0;
            k_q     <= '0;
            km_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            x_q     <= x_d;
            k_q     <= k_d;
            km_q    <= km_d;
            key_q   <= key_d;
        end
    end
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        si_d           = si_q;
        sj_d           = sj_q;
        x_d            = x_q;
        k_d            = k_q;
        km_d           = km_q;
        key_d          = key_q;
        bus.busy       = !(state_q inside {IDLE, DONE});
        bus.done       = 1'b0;
        bus.s_address  = '0;
        bus.s_data     = '0;
        bus.s_wren     = 1'b0;
        bus.pt_address = '0;
        bus.ct_address = '0;
        bus.ct_data    = '0;
        bus.ct_wren    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                key_d   = bus.key;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                km_d    = '0;
                state_d = INIT;
            end
            INIT: begin
                bus.s_address = i_q;
                bus.s_data    = i_q;
                bus.s_wren    = 1'b1;
                i_d           = i_q + 8'd1;
                state_d       = i_q == 8'hFF ? KSA_RD_I : INIT;
            end
            KSA_RD_I: begin
                bus.s_address = i_q;
                state_d       = KSA_WT_I;
            end
            KSA_WT_I: begin
                bus.s_address = i_q;
                si_d          = bus.s_q;
                state_d       = KSA_J;
            end
            KSA_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = KSA_RD_J;
            end
            KSA_RD_J: begin
                bus.s_address = j_q;
                state_d       = KSA_WT_J;
            end
            KSA_WT_J: begin
                bus.s_address = j_q;
                sj_d          = bus.s_q;
                state_d       = KSA_WR_I;
            end
            KSA_WR_I: begin
                bus.s_address = i_q;
                bus.s_data    = sj_q;
                bus.s_wren    = 1'b1;
                state_d       = KSA_WR_J;
            end
            // writing the captured si keeps S intact when i == j
            KSA_WR_J: begin
                bus.s_address = j_q;
                bus.s_data    = si_q;
                bus.s_wren    = 1'b1;
                km_d          = km_q == KW'(KEY_BYTES - 1) ? '0 : km_q + 1'b1;
                i_d           = i_q + 8'd1;
                j_d           = i_q == 8'hFF ? 8'd0 : j_q;
                state_d       = i_q == 8'hFF ? PR_INC : KSA_RD_I;
            end
            PR_INC: begin
                i_d     = i_q + 8'd1;
                state_d = PR_RD_I;
            end
            PR_RD_I: begin
                bus.s_address = i_q;
                state_d       = PR_WT_I;
            end
            PR_WT_I: begin
                bus.s_address = i_q;
                si_d          = bus.s_q;
                j_d           = j_q + bus.s_q;
                state_d       = PR_RD_J;
            end
            PR_RD_J: begin
                bus.s_address = j_q;
                state_d       = PR_WT_J;
            end
            PR_WT_J: begin
                bus.s_address = j_q;
                sj_d          = bus.s_q;
                state_d       = PR_WR_I;
            end
            PR_WR_I: begin
                bus.s_address = i_q;
                bus.s_data    = sj_q;
                bus.s_wren    = 1'b1;
                state_d       = PR_WR_J;
            end
            PR_WR_J: begin
                bus.s_address = j_q;
                bus.s_data    = si_q;
                bus.s_wren    = 1'b1;
                state_d       = PR_RD_F;
            end
            PR_RD_F: begin
                bus.s_address  = si_q + sj_q;
                bus.pt_address = k_q;
                state_d        = PR_WT_F;
            end
            PR_WT_F: begin
                bus.s_address  = si_q + sj_q;
                bus.pt_address = k_q;
                x_d            = bus.s_q ^ bus.pt_q;
                state_d        = WRITE_CT;
            end
            WRITE_CT: begin
                bus.ct_address = k_q;
                bus.ct_data    = x_q;
                bus.ct_wren    = 1'b1;
                k_d            = k_q + 1'b1;
                state_d        = k_q == ADDR_W'(MSG_LEN - 1) ? DONE : PR_INC;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
